// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD DAT-line receive path and its CRC16 engine.
package sd_dat_pkg;

    localparam int unsigned WORD_W_DEFAULT = 32;
    localparam int unsigned CRC_W = 16;
    localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;

    typedef enum logic [2:0] {
        StIdle,
        StWaitStart,
        StData,
        StCrc,
        StEnd,
        StReport
    } state_e;

endpackage

// File: rtl/sd_dat_rx_ctrl_if.sv
// Host/deserializer-facing signal bundle of the SD DAT receive controller.
interface sd_dat_rx_ctrl_if
    import sd_dat_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEFAULT,
    parameter int unsigned BLK_W  = 8,
    parameter int unsigned TMO_W  = 16
);
    logic              start;
    logic              abort;
    logic [BLK_W-1:0]  block_words;
    logic [TMO_W-1:0]  timeout_cycles;
    logic              dat_serial;
    logic              deser_enable;
    logic              deser_reset;
    logic [WORD_W-1:0] deser_parallel;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              busy;
    logic              done;
    logic              crc_error;
    logic              end_error;
    logic              timeout_error;

    modport master (
        output start, abort, block_words, timeout_cycles, dat_serial, deser_parallel,
        input  deser_enable, deser_reset, word_out, word_valid, busy, done,
               crc_error, end_error, timeout_error
    );

    modport slave (
        input  start, abort, block_words, timeout_cycles, dat_serial, deser_parallel,
        output deser_enable, deser_reset, word_out, word_valid, busy, done,
               crc_error, end_error, timeout_error
    );

endinterface

// File: rtl/crc16_serial.sv
// Bit-serial CRC16-CCITT (poly 0x1021, init 0, MSB first); shared by the RX and TX paths.
module crc16_serial
    import sd_dat_pkg::*;
(
    input  logic             sd_clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             fb;

    always_comb begin
        fb    = crc_q[CRC_W-1] ^ bit_in;
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (enable) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
        end
    end

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_dat_rx_ctrl.sv
// Receive sequencer for one SD data block on DAT0: start-bit search, word framing for the
// external deserializer, then CRC16 and end-bit checks with sticky error reporting.
module sd_dat_rx_ctrl
    import sd_dat_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEFAULT,
    parameter int unsigned BLK_W  = 8,
    parameter int unsigned TMO_W  = 16
) (
    input logic             sd_clock,
    input logic             reset,
    sd_dat_rx_ctrl_if.slave bus
);
    localparam int unsigned      BIT_W        = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0] LAST_CRC_BIT = BIT_W'(CRC_W - 1);

    state_e            state_q, state_d;
    logic [BLK_W-1:0]  blk_q, blk_d, word_cnt_q, word_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d, timer_q, timer_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              cap_q, cap_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              wvalid_q, wvalid_d;
    logic              drst_q, drst_d;
    logic [CRC_W-1:0]  crc_rx_q, crc_rx_d;
    logic              crc_err_q, crc_err_d, end_err_q, end_err_d, tmo_err_q, tmo_err_d;
    logic              crc_clear, crc_en;
    logic [CRC_W-1:0]  crc_calc;

    crc16_serial u_crc (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clear    (crc_clear),
        .enable   (crc_en),
        .bit_in   (bus.dat_serial),
        .crc      (crc_calc)
    );

    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        word_cnt_d = word_cnt_q;
        tmo_d      = tmo_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        cap_d      = 1'b0;
        word_d     = word_q;
        wvalid_d   = 1'b0;
        drst_d     = 1'b0;
        crc_rx_d   = crc_rx_q;
        crc_err_d  = crc_err_q;
        end_err_d  = end_err_q;
        tmo_err_d  = tmo_err_q;
        crc_clear  = 1'b0;
        crc_en     = 1'b0;

        // Capture lands one edge after bit 31, overlapping the next word's first bit.
        if (cap_q) begin
            word_d   = bus.deser_parallel;
            wvalid_d = 1'b1;
        end

        if (bus.abort && state_q != StIdle) begin
            state_d   = StIdle;
            drst_d    = 1'b1;
            word_d    = word_q;
            wvalid_d  = 1'b0;
            crc_err_d = 1'b0;
            end_err_d = 1'b0;
            tmo_err_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start && bus.block_words != '0) begin
                        blk_d     = bus.block_words;
                        tmo_d     = bus.timeout_cycles;
                        timer_d   = '0;
                        crc_err_d = 1'b0;
                        end_err_d = 1'b0;
                        tmo_err_d = 1'b0;
                        crc_clear = 1'b1;
                        drst_d    = 1'b1;
                        state_d   = StWaitStart;
                    end
                end
                StWaitStart: begin
                    timer_d = timer_q + 1'b1;
                    if (!bus.dat_serial) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        state_d    = StData;
                    end else if (tmo_q != '0 && timer_d == tmo_q) begin
                        tmo_err_d = 1'b1;
                        state_d   = StReport;
                    end
                end
                StData: begin
                    crc_en    = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + 1'b1;
                        cap_d      = 1'b1;
                        if (word_cnt_d == blk_q) begin
                            state_d = StCrc;
                        end
                    end
                end
                StCrc: begin
                    crc_rx_d  = {crc_rx_q[CRC_W-2:0], bus.dat_serial};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_CRC_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = StEnd;
                    end
                end
                StEnd: begin
                    end_err_d = ~bus.dat_serial;
                    crc_err_d = (crc_rx_q != crc_calc);
                    state_d   = StReport;
                end
                StReport: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            blk_q      <= '0;
            word_cnt_q <= '0;
            tmo_q      <= '0;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            cap_q      <= 1'b0;
            word_q     <= '0;
            wvalid_q   <= 1'b0;
            drst_q     <= 1'b0;
            crc_rx_q   <= '0;
            crc_err_q  <= 1'b0;
            end_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            word_cnt_q <= word_cnt_d;
            tmo_q      <= tmo_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            cap_q      <= cap_d;
            word_q     <= word_d;
            wvalid_q   <= wvalid_d;
            drst_q     <= drst_d;
            crc_rx_q   <= crc_rx_d;
            crc_err_q  <= crc_err_d;
            end_err_q  <= end_err_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign bus.deser_enable  = (state_q == StData);
    assign bus.deser_reset   = drst_q;
    assign bus.word_out      = word_q;
    assign bus.word_valid    = wvalid_q;
    assign bus.busy          = (state_q != StIdle);
    assign bus.done          = (state_q == StReport);
    assign bus.crc_error     = crc_err_q;
    assign bus.end_error     = end_err_q;
    assign bus.timeout_error = tmo_err_q;

endmodule

// File: tb/tb_sd_dat_rx_ctrl.sv
// Bench for sd_dat_rx_ctrl: directed blocks against a cycle-schedule model with its own
// deserializer and long-division CRC16.
module tb_sd_dat_rx_ctrl;
    localparam int unsigned WW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned TW = 16;
    localparam int          NEVER = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    sd_dat_rx_ctrl_if #(.WORD_W(WW), .BLK_W(BW), .TMO_W(TW)) bus ();

    sd_dat_rx_ctrl #(.WORD_W(WW), .BLK_W(BW), .TMO_W(TW)) dut (
        .sd_clock (clk),
        .reset    (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External deserializer: MSB-first shift register.
    logic [WW-1:0] deser_q;
    always @(posedge clk or posedge rst) begin
        if (rst) deser_q <= '0;
        else if (bus.deser_reset) deser_q <= '0;
        else if (bus.deser_enable) deser_q <= {deser_q[WW-2:0], bus.dat_serial};
    end
    assign bus.deser_parallel = deser_q;

    // Expected-behaviour schedule, in absolute cycle numbers.
    typedef struct {
        int          c;
        logic [31:0] w;
    } wexp_t;
    wexp_t       wq[$];
    int          m_busy_lo = 1, m_busy_hi = 0, m_den_lo = 1, m_den_hi = 0;
    int          m_done = -1, m_drst_s = -1, m_drst_a = -1;
    int          m_fl_clr = 0, m_fl_set = 0;
    logic [2:0]  m_fl_old = 3'b000, m_fl_new = 3'b000;
    logic [31:0] words[4];
    int          g_s = 0, last_wv_cyc = -1, last_done_cyc = -1;
    int          n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] fl_exp(input int c);
        if (c < m_fl_clr) return m_fl_old;
        if (c < m_fl_set) return 3'b000;
        return m_fl_new;
    endfunction

    // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] crc_model(input bit m[$]);
        logic [16:0] r = '0;
        for (int i = 0; i < m.size() + 16; i++) begin
            r = {r[15:0], (i < m.size()) ? m[i] : 1'b0};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    always @(negedge clk) begin
        logic exp_wv;
        if (rst) begin
            chk("reset_outputs", {bus.word_valid, bus.busy, bus.done, bus.deser_enable,
                bus.deser_reset, bus.crc_error, bus.end_error, bus.timeout_error, bus.word_out},
                64'd0);
        end else begin
            chk("busy", bus.busy, cyc >= m_busy_lo && cyc <= m_busy_hi);
            chk("deser_enable", bus.deser_enable, cyc >= m_den_lo && cyc <= m_den_hi);
            chk("deser_reset", bus.deser_reset, cyc == m_drst_s || cyc == m_drst_a);
            chk("done", bus.done, cyc == m_done);
            chk("err_flags", {bus.crc_error, bus.end_error, bus.timeout_error}, fl_exp(cyc));
            exp_wv = 1'b0;
            if (wq.size() > 0) exp_wv = (wq[0].c == cyc);
            chk("word_valid", bus.word_valid, exp_wv);
            if (exp_wv) begin
                if (bus.word_valid) chk("word_out", bus.word_out, wq[0].w);
                void'(wq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.word_valid) last_wv_cyc <= cyc;
        if (!rst && bus.done) last_done_cyc <= cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cut_mode: 0 none, 1 abort on stream bit cut_at, 2 reset just before it.
    task automatic run_block(input int nb, input int idle, input int tmo, input int flip,
                             input logic endb, input int cut_mode, input int cut_at);
        bit          s[$];
        bit          dbits[$];
        logic [15:0] crc;
        int          d0, ee, x;
        bit          stop = 0;
        wexp_t       e;
        for (int i = 0; i < idle; i++) s.push_back(1'b1);
        s.push_back(1'b0);
        for (int k = 0; k < nb; k++) begin
            for (int b = WW - 1; b >= 0; b--) begin
                s.push_back(words[k][b]);
                dbits.push_back(words[k][b]);
            end
        end
        crc = crc_model(dbits);
        for (int b = 15; b >= 0; b--) s.push_back(crc[b] ^ (b == flip));
        s.push_back(endb);

        g_s = cyc + 1;
        d0  = g_s + idle + 1;
        ee  = d0 + 32 * nb + 17;
        m_fl_old  = fl_exp(cyc);
        m_fl_clr  = g_s;
        m_fl_set  = ee;
        m_fl_new  = {flip >= 0, ~endb, 1'b0};
        m_busy_lo = g_s;
        m_busy_hi = ee;
        m_den_lo  = d0;
        m_den_hi  = d0 + 32 * nb - 1;
        m_done    = ee;
        m_drst_s  = g_s;
        m_drst_a  = -1;
        for (int k = 0; k < nb; k++) begin
            e.c = d0 + 32 * (k + 1) + 1;
            e.w = words[k];
            wq.push_back(e);
        end

        bus.start          = 1'b1;
        bus.block_words    = BW'(nb);
        bus.timeout_cycles = TW'(tmo);
        tick();
        for (int i = 0; i < s.size() && !stop; i++) begin
            x = g_s + 1 + i;
            bus.start = (i == idle + 5);  // ignored while busy
            if (cut_mode == 1 && i == cut_at) begin
                m_fl_old  = fl_exp(x - 1);
                m_fl_clr  = x;
                m_fl_set  = NEVER;
                m_fl_new  = 3'b000;
                m_busy_hi = x - 1;
                if (m_den_hi > x - 1) m_den_hi = x - 1;
                m_done   = -1;
                m_drst_a = x;
                while (wq.size() > 0 && wq[wq.size() - 1].c >= x) void'(wq.pop_back());
                bus.abort = 1'b1;
                stop = 1;
            end else if (cut_mode == 2 && i == cut_at) begin
                #2;
                wq.delete();
                m_busy_lo = 1; m_busy_hi = 0; m_den_lo = 1; m_den_hi = 0;
                m_done = -1; m_drst_s = -1; m_drst_a = -1;
                m_fl_old = 3'b000; m_fl_new = 3'b000; m_fl_clr = 0; m_fl_set = 0;
                rst = 1'b1;
                #1;
                chk("async_reset", {bus.word_valid, bus.busy, bus.done, bus.deser_enable,
                    bus.deser_reset, bus.crc_error, bus.end_error, bus.timeout_error}, 64'd0);
                tick();
                rst = 1'b0;
                stop = 1;
            end
            bus.dat_serial = s[i];
            tick();
            bus.abort = 1'b0;
        end
        bus.start      = 1'b0;
        bus.dat_serial = 1'b1;
        repeat (3) tick();
    endtask

    task automatic run_timeout(input int tmo, input int run_cycles);
        int a;
        g_s = cyc + 1;
        m_fl_old = fl_exp(cyc);
        m_fl_clr = g_s;
        m_drst_s = g_s;
        m_drst_a = -1;
        m_den_lo = 1;
        m_den_hi = 0;
        m_busy_lo = g_s;
        if (tmo != 0) begin
            m_fl_set = g_s + tmo; m_fl_new = 3'b001; m_busy_hi = g_s + tmo; m_done = g_s + tmo;
        end else begin
            m_fl_set = NEVER; m_fl_new = 3'b000; m_busy_hi = NEVER; m_done = -1;
        end
        bus.start          = 1'b1;
        bus.block_words    = 8'd4;
        bus.timeout_cycles = TW'(tmo);
        bus.dat_serial     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (run_cycles) tick();
        if (tmo == 0) begin
            a = cyc + 1;
            m_fl_old = fl_exp(a - 1); m_fl_clr = a; m_fl_set = NEVER; m_fl_new = 3'b000;
            m_busy_hi = a - 1;
            m_drst_a = a;
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
        end
        repeat (3) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   pin[$];
        byte  ch;
        string digits = "123456789";
        bus.start = 1'b0; bus.abort = 1'b0; bus.block_words = '0;
        bus.timeout_cycles = '0; bus.dat_serial = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Pin the CRC model against known remainders.
        for (int i = 0; i < digits.len(); i++) begin
            ch = digits[i];
            for (int b = 7; b >= 0; b--) pin.push_back(ch[b]);
        end
        chk("crc_model_123456789", crc_model(pin), 16'h31C3);
        pin.delete();
        pin.push_back(1'b1);
        chk("crc_model_single_one", crc_model(pin), 16'h1021);

        // Single word, clean block.
        words[0] = 32'hA5A50F0F;
        run_block(1, 3, 0, -1, 1'b1, 0, 0);
        chk("t1_word_latency", last_wv_cyc - g_s, 37);
        chk("t1_done_latency", last_done_cyc - g_s, 53);

        // Four words.
        words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3; words[3] = 32'h4;
        run_block(4, 2, 0, -1, 1'b1, 0, 0);

        // CRC bit flipped, then a clean block clears the flag.
        words[0] = 32'hA5A50F0F;
        run_block(1, 3, 0, 5, 1'b1, 0, 0);
        run_block(1, 3, 0, -1, 1'b1, 0, 0);

        // Bad end bit.
        run_block(1, 3, 0, -1, 1'b0, 0, 0);

        // Start bit on the same edge the timer reaches its limit: start bit wins.
        words[0] = 32'h8000_0001;
        run_block(1, 3, 4, -1, 1'b1, 0, 0);

        // block_words == 0 is ignored.
        bus.start = 1'b1; bus.block_words = '0; tick(); bus.start = 1'b0;
        repeat (4) tick();

        // Timeouts.
        run_timeout(10, 15);
        chk("t5_timeout_latency", last_done_cyc - g_s, 10);
        run_timeout(0, 1000);

        // Reset mid word 2, then a full block.
        words[0] = 32'hDEADBEEF; words[1] = 32'h0123_4567;
        words[2] = 32'hFFFF_0000; words[3] = 32'h5A5A_C3C3;
        run_block(4, 3, 0, -1, 1'b1, 2, 46);
        run_block(4, 3, 0, -1, 1'b1, 0, 0);

        // Abort mid word 3.
        run_block(4, 3, 0, -1, 1'b1, 1, 78);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sd_dat_rx_ctrl.md
Name: sd_dat_rx_ctrl

Overview:
- Sequences reception of one SD data block on DAT0 through the existing 32-bit serial-to-parallel deserializer.
- Detects the start bit, gates the deserializer enable for block_words x 32 bits, and hands each assembled word downstream.
- Checks the trailing CRC16 and end bit, then reports completion and error status to the host command/DMA logic.

Parameters:
- WORD_W, 32, deserializer word width in bits.
- BLK_W, 8, width of block_words (max 255 words per block).
- TMO_W, 16, width of the start-bit timeout counter.

Ports:
- sd_clock  in  1  SD bus clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  one-cycle request to receive a block; honoured only in IDLE.
- abort  in  1  cancels any operation in progress.
- block_words  in  BLK_W  words per block; latched on start.
- timeout_cycles  in  TMO_W  start-bit wait limit; latched on start; 0 = wait forever.
- dat_serial  in  1  DAT0 line.
- deser_enable  out  1  enable to the deserializer.
- deser_reset  out  1  one-cycle clear pulse to the deserializer.
- deser_parallel  in  WORD_W  deserializer output.
- word_out  out  WORD_W  captured data word.
- word_valid  out  1  one-cycle strobe qualifying word_out.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of block (success or error).
- crc_error  out  1  sticky until next accepted start.
- end_error  out  1  sticky until next accepted start.
- timeout_error  out  1  sticky until next accepted start.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. Reset mid-operation returns to IDLE immediately; no done pulse.
- IDLE
  - start with block_words != 0: latch block_words and timeout_cycles; clear error flags and CRC; assert deser_reset for one cycle; go to WAIT_START.
  - start with block_words == 0 is ignored.
  - start while busy is ignored.
- WAIT_START
  - Timer increments every cycle.
  - dat_serial sampled 0: go to DATA with bit_cnt = 0 and word_cnt = 0.
  - Timer == timeout_cycles (nonzero) before a start bit: set timeout_error, go to REPORT.
  - Start bit and timeout on the same edge: the start bit wins.
- DATA
  - deser_enable = 1 for the whole state; each cycle dat_serial feeds the CRC, MSB first.
  - bit_cnt wraps 31 -> 0.
  - On the edge sampling bit 31: increment word_cnt and set capture_pending.
  - On the next edge: word_out <= deser_parallel and word_valid = 1 for exactly one cycle. This overlaps the first bit of the next word, so words arrive exactly 32 cycles apart.
  - After the bit-31 edge of word block_words: go to CRC. The final capture still occurs on the following edge.
- CRC
  - deser_enable = 0; shift 16 received bits into crc_rx, MSB first; the CRC engine is frozen.
- END
  - Sample dat_serial once; 0 sets end_error.
  - Set crc_error if crc_rx != computed CRC.
  - Go to REPORT.
- REPORT
  - done = 1 for one cycle; go to IDLE. Error flags persist.
- abort, any non-IDLE state
  - Next edge: IDLE, deser_reset pulse, deser_enable 0, no done, error flags cleared.
  - abort has priority over all other transitions.
- CRC
  - CRC16-CCITT, polynomial 0x1021, init 0x0000, no reflection, no final XOR; covers data bits only.
- Widths
  - word_cnt is BLK_W bits; it is compared with the latched block_words, so there is no wrap-around.

Decomposition:
- Package sd_dat_pkg:
  - state enum (IDLE, WAIT_START, DATA, CRC, END, REPORT)
  - CRC16_POLY = 16'h1021
  - CRC_W = 16
  - WORD_W default
- Sub-module crc16_serial:
  - inputs: sd_clock, reset, clear, enable, bit_in
  - output: crc[15:0]
  - shared later with the TX path.
- The deserializer stays external; this block only drives its enable and reset.

Test Plan:
1. block_words=1, DAT idle high 3 cycles, start bit, word 0xA5A50F0F, correct CRC, end bit 1 -> one word_valid with 0xA5A50F0F; done 1 cycle; all error flags 0; busy falls after done.
2. block_words=4, words 0x00000001..0x00000004 -> four word_valid pulses exactly 32 cycles apart, in order; done after CRC and end bit; no errors.
3. Case 1 with one CRC bit inverted -> crc_error=1, done pulse, end_error=0. A following correct block clears crc_error on start.
4. Case 1 with end bit 0 -> end_error=1, crc_error=0, done pulse.
5. timeout_cycles=10, DAT held 1 -> timeout_error=1 and done on the 10th WAIT_START cycle; deser_enable never asserted. Repeat with timeout_cycles=0 for 1000 cycles -> still busy, no done.
6. block_words=4:
   - reset asserted mid word 2 -> all outputs 0 at once; a subsequent start receives a full block correctly.
   - abort mid word 3 -> no done, deser_reset pulse, busy low next cycle.
